wgt_rf_loader: RTL and testbench

//  Feeder for one wgt_shift_RF. Fetches one filter (BUFFER_SIZE weights) from the weight SRAM.

---
 rtl/wgt_rf_loader_pkg.sv | 18 +
 rtl/wgt_rf_loader_rd_pipe.sv | 38 +++
 rtl/wgt_rf_loader.sv | 126 ++++++++++++
 tb/tb_wgt_rf_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wgt_rf_loader_pkg.sv
// Shared definitions for the weight RF loader: default geometry and FSM states.
package wgt_rf_loader_pkg;

  localparam int unsigned WGT_DATA_WIDTH  = 8;
  localparam int unsigned WGT_BUFFER_SIZE = 27;
  localparam int unsigned WGT_ADDR_WIDTH  = 12;
  localparam int unsigned WGT_FIDX_WIDTH  = 6;
  localparam int unsigned WGT_WIN_WIDTH   = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } ldr_state_t;

endpackage

// File: rtl/wgt_rf_loader_rd_pipe.sv
// Read alignment pipe: lines SRAM data up with its read strobe and drives the
// registered RF-side outputs (data, shift enable, select, valid).
module wgt_rf_loader_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  stream_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  shift_en,
  output logic                  select_wgt,
  output logic                  wgt_valid
);

  logic rd_en_d1;

  // Stage 1 marks the cycle SRAM data is valid; stage 2 captures it and shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_d1   <= 1'b0;
      data_out   <= '0;
      shift_en   <= 1'b0;
      select_wgt <= 1'b0;
      wgt_valid  <= 1'b0;
    end else begin
      rd_en_d1   <= rd_en;
      shift_en   <= rd_en_d1 | stream_en;
      select_wgt <= rd_en_d1;
      wgt_valid  <= stream_en;
      if (rd_en_d1) begin
        data_out <= rd_data;
      end
    end
  end

endmodule

// File: rtl/wgt_rf_loader.sv
// Weight RF loader: fetches one filter from the weight SRAM into a shift RF,
// then recirculates it once per output window.
module wgt_rf_loader
  import wgt_rf_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = WGT_DATA_WIDTH,
  parameter int unsigned BUFFER_SIZE = WGT_BUFFER_SIZE,
  parameter int unsigned ADDR_WIDTH  = WGT_ADDR_WIDTH,
  parameter int unsigned FIDX_WIDTH  = WGT_FIDX_WIDTH,
  parameter int unsigned WIN_WIDTH   = WGT_WIN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FIDX_WIDTH-1:0] filter_idx,
  input  logic [WIN_WIDTH-1:0]  num_windows,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  select_wgt,
  output logic                  wgt_RF_shift_en,
  output logic                  wgt_valid
);

  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BUFFER_SIZE - 1);

  ldr_state_t            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [WIN_WIDTH-1:0]  nw_q;
  logic [WIN_WIDTH-1:0]  win_cnt;
  logic [CNT_W-1:0]      idx_cnt;
  logic                  stream_en;

  // A stream shift happens in every non-held STREAM cycle.
  always_comb begin
    stream_en = (state == ST_STREAM) && !hold;
  end

  // Job sequencer: idx_cnt is the load index, the drain count and the round position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      nw_q        <= '0;
      win_cnt     <= '0;
      idx_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            base_q  <= ADDR_WIDTH'(filter_idx * BUFFER_SIZE);
            nw_q    <= num_windows;
            win_cnt <= '0;
            idx_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= base_q + ADDR_WIDTH'(idx_cnt);
          if (idx_cnt == LAST_IDX) begin
            idx_cnt <= '0;
            state   <= ST_DRAIN;
          end else begin
            idx_cnt <= idx_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          mem_rd_en <= 1'b0;
          if (idx_cnt == CNT_W'(1)) begin
            idx_cnt <= '0;
            state   <= (nw_q == '0) ? ST_DONE : ST_STREAM;
          end else begin
            idx_cnt <= idx_cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          if (!hold) begin
            if (idx_cnt == LAST_IDX) begin
              idx_cnt <= '0;
              if ((win_cnt + WIN_WIDTH'(1)) == nw_q) begin
                state <= ST_DONE;
              end else begin
                win_cnt <= win_cnt + 1'b1;
              end
            end else begin
              idx_cnt <= idx_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wgt_rf_loader_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (mem_rd_en),
    .rd_data   (mem_rd_data),
    .stream_en (stream_en),
    .data_out  (data_out),
    .shift_en  (wgt_RF_shift_en),
    .select_wgt(select_wgt),
    .wgt_valid (wgt_valid)
  );

endmodule

// File: tb/tb_wgt_rf_loader.sv
// Bench for wgt_rf_loader: SRAM model (mem[a]=a[7:0]), a 27-deep shift RF
// model, and a job-timeline reference model checked every cycle.
module tb_wgt_rf_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  filter_idx;
  logic [9:0]  num_windows;
  logic        hold;
  logic        busy, done, mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = '0;
  logic [7:0]  data_out;
  logic        select_wgt, wgt_RF_shift_en, wgt_valid;

  always #5 clk = ~clk;

  wgt_rf_loader #(
    .DATA_WIDTH(8), .BUFFER_SIZE(27), .ADDR_WIDTH(12), .FIDX_WIDTH(6), .WIN_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter_idx(filter_idx),
    .num_windows(num_windows), .hold(hold), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .data_out(data_out), .select_wgt(select_wgt),
    .wgt_RF_shift_en(wgt_RF_shift_en), .wgt_valid(wgt_valid)
  );

  // 1-cycle-latency SRAM whose content is the low byte of the address
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];

  // Downstream shift RF: rf[0] is the weight presented to the PE
  logic [7:0] rf [27] = '{default: 8'h00};
  logic [7:0] rf_head;
  always @(posedge clk) begin
    if (wgt_RF_shift_en) begin
      rf_head = rf[0];
      for (int i = 0; i < 26; i++) rf[i] = rf[i+1];
      rf[26] = select_wgt ? data_out : rf_head;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: job timeline relative to the start-sampling edge
  int m_active = 0, m_t = 0, m_base = 0, m_nw = 0, m_str = 0, m_vc = 0, m_data = 0;
  int exp_busy, exp_done, exp_rd, exp_addr, exp_shift, exp_sel, exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task model_step(input logic s, input logic h);
    exp_done = 0; exp_rd = 0; exp_shift = 0; exp_sel = 0; exp_valid = 0;
    if (!m_active) begin
      exp_busy = 0;
      if (s) begin
        m_active = 1; m_t = 0; m_str = 0; m_vc = 0;
        m_base = (int'(filter_idx) * 27) % 4096;
        m_nw = int'(num_windows);
        exp_busy = 1;
      end
    end else begin
      m_t++;
      exp_busy = 1;
      if (m_t >= 1 && m_t <= 27) begin
        exp_rd = 1; exp_addr = (m_base + m_t - 1) % 4096;
      end
      if (m_t >= 3 && m_t <= 29) begin
        exp_shift = 1; exp_sel = 1; m_data = (m_base + m_t - 3) % 256;
      end
      if (m_t >= 30) begin
        if (m_str == 27 * m_nw) begin
          exp_done = 1; exp_busy = 0; m_active = 0;
        end else if (!h) begin
          exp_shift = 1; exp_valid = 1; m_str++;
        end
      end
    end
  endtask

  task check_outputs();
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
    if (exp_rd != 0) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_addr));
    chk("shift_en", 32'(wgt_RF_shift_en), 32'(exp_shift));
    chk("select_wgt", 32'(select_wgt), 32'(exp_sel));
    chk("wgt_valid", 32'(wgt_valid), 32'(exp_valid));
    chk("data_out", 32'(data_out), 32'(m_data));
    if (exp_valid != 0) begin
      chk("rf_out", 32'(rf[0]), 32'((m_base + (m_vc % 27)) % 256));
      m_vc++;
    end
  endtask

  task tick(input logic s, input logic h);
    start = s; hold = h;
    @(posedge clk); #1;
    model_step(s, h);
    check_outputs();
  endtask

  // Called 1 time unit after an edge; asynchronous reset must clear outputs at once
  task do_reset();
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    #2;
    m_active = 0; m_data = 0;
    exp_busy = 0; exp_done = 0; exp_rd = 0; exp_shift = 0; exp_sel = 0; exp_valid = 0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_en", 32'(mem_rd_en), 32'(0));
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'(0));
    chk("rst_shift_en", 32'(wgt_RF_shift_en), 32'(0));
    chk("rst_select", 32'(select_wgt), 32'(0));
    chk("rst_valid", 32'(wgt_valid), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    #3 rst_n = 1'b1;
  endtask

  // hold_mode: 0 none, 1 random, 2 five-cycle hold at round 1 weight 10
  task run_job(input int fidx, input int nw, input int hold_mode, input int restart_at,
               input int abort_at, output int done_at, output int n_done);
    int hcnt;
    logic h;
    hcnt = 0; done_at = -1; n_done = 0;
    filter_idx = 6'(fidx); num_windows = 10'(nw);
    tick(1'b1, 1'b0);
    filter_idx = 6'($urandom); num_windows = 10'($urandom);
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (cyc == abort_at) begin
        do_reset();
        break;
      end
      h = 1'b0;
      if (hold_mode == 1) h = ($urandom_range(0, 3) == 0);
      if (hold_mode == 2 && m_str == 37 && hcnt < 5) begin h = 1'b1; hcnt++; end
      tick(cyc == restart_at, h);
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (!m_active) break;
    end
    start = 1'b0; hold = 1'b0;
  endtask

  int dat, nd;

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; filter_idx = '0; num_windows = '0;
    @(posedge clk); #1;
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);

    // filter 0, one window: done at t0+57
    run_job(0, 1, 0, -1, -1, dat, nd);
    chk("t1_done_time", 32'(dat), 32'(57));
    chk("t1_done_count", 32'(nd), 32'(1));

    // filter 2, three windows: addresses 54..80, 81 valid cycles
    run_job(2, 3, 0, -1, -1, dat, nd);
    chk("t2_done_time", 32'(dat), 32'(30 + 81));
    chk("t2_done_count", 32'(nd), 32'(1));

    // load only
    run_job(5, 0, 0, -1, -1, dat, nd);
    chk("t3_done_time", 32'(dat), 32'(30));

    // five-cycle hold mid-stream delays done by five
    run_job(1, 2, 2, -1, -1, dat, nd);
    chk("t4_done_time", 32'(dat), 32'(30 + 54 + 5));

    // back-to-back start right after done, random holds everywhere
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1, -1, -1, dat, nd);
      chk("rand_done_count", 32'(nd), 32'(1));
    end

    // start pulsed during LOAD is ignored
    run_job(63, 1, 1, 10, -1, dat, nd);
    chk("t5_single_done", 32'(nd), 32'(1));

    // reset mid-STREAM, then a fresh job runs normally
    run_job(7, 2, 0, -1, 45, dat, nd);
    tick(1'b0, 1'b0);
    run_job(9, 1, 0, -1, -1, dat, nd);
    chk("t5_post_reset_done_time", 32'(dat), 32'(57));
    chk("t5_post_reset_done_count", 32'(nd), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
